tag_scoreboard: RTL and testbench
=================================

# tag_scoreboard

Per-warp register scoreboard and tag allocator between the decoder and the `wait_buffer`. Each decoded instruction receives a free completion tag. Each source operand is resolved to "ready" or "waiting on producer tag X". The result is registered in a one-entry output stage that feeds the wait buffer. Tags and destination mappings are released when an execution unit reports completion on the shared `eu_valid_i`/`eu_tag_i` bus, which the wait buffer also snoops.

## Interface
- `NumTags`, 8: completion tags per warp; ≥2.
- `RegIdxWidth`, 6: register index width.
- `OperandsPerInst`, 2: source operands per instruction.
- `PayloadWidth`, 64: opaque payload (pc, act_mask, inst) carried unchanged.
- `TagWidth`, `$clog2(NumTags)`: derived; do not override.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `dec_valid_i`  in  1  decoded instruction valid.
- `sb_ready_o`  out  1  instruction accepted this cycle if `dec_valid_i`.
- `dec_payload_i`  in  PayloadWidth  opaque payload.
- `dec_has_dst_i`  in  1  instruction writes `dec_dst_reg_i`.
- `dec_dst_reg_i`  in  RegIdxWidth  destination register.
- `dec_operands_required_i`  in  OperandsPerInst  operand used mask.
- `dec_operands_i`  in  OperandsPerInst×RegIdxWidth  source registers.
- `wb_valid_o`  out  1  output stage valid.
- `wb_ready_i`  in  1  wait buffer accepts.
- `wb_payload_o`, `wb_dst_reg_o`, `wb_operands_required_o`, `wb_operands_o`  out  as inputs  registered copies.
- `wb_tag_o`  out  TagWidth  allocated tag.
- `wb_operands_ready_o`  out  OperandsPerInst  operand resolved (unused operands read 1).
- `wb_operand_tags_o`  out  OperandsPerInst×TagWidth  producer tag per waiting operand.
- `eu_valid_i`  in  1  completion strobe.
- `eu_tag_i`  in  TagWidth  completed tag.

## Operation
- State:
  - `tag_busy_q[NumTags]`.
  - Per register: `reg_pending_q` and `reg_tag_q`.
  - Output register: `out_valid_q` plus fields.
- Allocation: the free tag is the lowest index with `tag_busy_q`=0, computed from registered state only. A tag freed this cycle is not reusable until the next cycle.
- `sb_ready_o = any_free_tag && (!out_valid_q || wb_ready_i)`.
- Accept (`dec_valid_i && sb_ready_o`):
  - Set `tag_busy` for the allocated tag.
  - If `dec_has_dst_i`: `reg_pending[dst]`=1 and `reg_tag[dst]`=allocated tag.
  - Load the output register.
- Every instruction allocates a tag, whether or not it has a destination.
- Operand lookup uses state from before this cycle's allocation. An instruction reading its own destination therefore sees the previous producer.
- Per required operand:
  - ready = `!reg_pending_q[r] || (eu_valid_i && eu_tag_i == reg_tag_q[r])`. The second term is a same-cycle writeback bypass.
  - tag = `reg_tag_q[r]`.
- Unrequired operands: ready=1, tag=0.
- Completion (`eu_valid_i`):
  - Clear `tag_busy[eu_tag_i]`.
  - Clear `reg_pending[r]` for every r with `reg_tag_q[r]==eu_tag_i`.
  - A same-cycle allocation to the same register wins: pending stays 1 with the new tag.
- Output snoop: while `out_valid_q`, any waiting operand whose tag equals `eu_tag_i` on `eu_valid_i` sets its ready bit. This applies also when stalled.
- `wb_ready_i` with `out_valid_q` and no accept clears `out_valid_q`.
- Completion for a non-busy tag is ignored. A simulation assertion fires.

## Timing
- Accept in cycle N gives `wb_valid_o` in N+1. Throughput is 1 instruction/cycle while `wb_ready_i`=1.
- Combinational paths: `wb_ready_i` → `sb_ready_o`, and `eu_*` → next-state only. `wb_*` outputs come from registers.
- Reset values:
  - `wb_valid_o`=0 and all `wb_*` fields 0.
  - All tags free and all registers not pending.
  - `sb_ready_o`=1 from the first cycle after reset deasserts.
- Reset mid-operation discards the output entry and all tag state in the same edge.
- Full: with all NumTags busy, `sb_ready_o`=0. A completion at cycle N allows an accept at N+1.

## Configuration
- `TAG_SCOREBOARD_FLUSH_EN` defined: adds port `flush_i` (in, 1).
  - Synchronous flush clears all `tag_busy`, all `reg_pending` and `out_valid_q` on the next edge.
  - While `flush_i`=1: `sb_ready_o`=0 and completions are ignored.
- Undefined: no port and no flush logic; state clears only on reset.

## Test plan
- Reset; accept dst r3, operands r1,r2 → next cycle `wb_valid_o`=1, tag 0, ready=2'b11.
- A: dst r5, gets tag 0. B: reads r5 with `wb_ready_i`=0 → tag 0, ready 0. Pulse `eu_tag_i`=0 → B's ready bit becomes 1 while stalled.
- Bypass: r5 pending on tag 2, `eu_valid_i` with tag 2 in the same cycle C reading r5 is accepted → C ready=1.
- Exhaustion: 8 accepts with no completion → `sb_ready_o`=0. Complete tag 3 → next accept gets tag 3.
- WAW: writers to r5 get tags 0 and 1. Complete tag 0 → a reader of r5 still sees tag 1, not ready.
- Flush (`TAG_SCOREBOARD_FLUSH_EN`): 4 busy tags, `flush_i` one cycle → `wb_valid_o`=0, next accept gets tag 0 with all operands ready.

Source files
------------

// File: rtl/tag_scoreboard.sv
// Per-warp register scoreboard and completion-tag allocator feeding the wait buffer.
// Optional synchronous flush port is enabled with `define TAG_SCOREBOARD_FLUSH_EN.
module tag_scoreboard #(
  parameter int NumTags         = 8,
  parameter int RegIdxWidth     = 6,
  parameter int OperandsPerInst = 2,
  parameter int PayloadWidth    = 64,
  parameter int TagWidth        = $clog2(NumTags)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
`ifdef TAG_SCOREBOARD_FLUSH_EN
  input  logic                                   flush_i,
`endif
  input  logic                                   dec_valid_i,
  output logic                                   sb_ready_o,
  input  logic [PayloadWidth-1:0]                dec_payload_i,
  input  logic                                   dec_has_dst_i,
  input  logic [RegIdxWidth-1:0]                 dec_dst_reg_i,
  input  logic [OperandsPerInst-1:0]             dec_operands_required_i,
  input  logic [OperandsPerInst*RegIdxWidth-1:0] dec_operands_i,
  output logic                                   wb_valid_o,
  input  logic                                   wb_ready_i,
  output logic [PayloadWidth-1:0]                wb_payload_o,
  output logic [RegIdxWidth-1:0]                 wb_dst_reg_o,
  output logic [OperandsPerInst-1:0]             wb_operands_required_o,
  output logic [OperandsPerInst*RegIdxWidth-1:0] wb_operands_o,
  output logic [TagWidth-1:0]                    wb_tag_o,
  output logic [OperandsPerInst-1:0]             wb_operands_ready_o,
  output logic [OperandsPerInst*TagWidth-1:0]    wb_operand_tags_o,
  input  logic                                   eu_valid_i,
  input  logic [TagWidth-1:0]                    eu_tag_i
);

  localparam int NumRegs = 1 << RegIdxWidth;

  logic                      flush;
  logic [NumTags-1:0]        tag_busy_q, tag_busy_d;
  logic [NumRegs-1:0]        reg_pending_q, reg_pending_d;
  logic [TagWidth-1:0]       reg_tag_q [NumRegs];
  logic [TagWidth-1:0]       reg_tag_d [NumRegs];
  logic [TagWidth-1:0]       free_tag;
  logic                      any_free;
  logic                      accept;
  logic                      eu_hit;
  logic [OperandsPerInst-1:0]          op_ready;
  logic [OperandsPerInst*TagWidth-1:0] op_tags;
  logic [OperandsPerInst-1:0]          snoop_ready;
  logic [RegIdxWidth-1:0]              src;

  logic                                   out_valid_q;
  logic [PayloadWidth-1:0]                out_payload_q;
  logic [RegIdxWidth-1:0]                 out_dst_q;
  logic [OperandsPerInst-1:0]             out_required_q;
  logic [OperandsPerInst*RegIdxWidth-1:0] out_operands_q;
  logic [TagWidth-1:0]                    out_tag_q;
  logic [OperandsPerInst-1:0]             out_ready_q;
  logic [OperandsPerInst*TagWidth-1:0]    out_op_tags_q;

`ifdef TAG_SCOREBOARD_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Lowest free tag, from registered state only so a tag freed this cycle waits a cycle.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = NumTags - 1; i >= 0; i--) begin
      if (!tag_busy_q[i]) begin
        free_tag = TagWidth'(i);
        any_free = 1'b1;
      end
    end
  end

  assign sb_ready_o = any_free && (!out_valid_q || wb_ready_i) && !flush;
  assign accept     = dec_valid_i && sb_ready_o;
  assign eu_hit     = eu_valid_i && tag_busy_q[eu_tag_i] && !flush;

  always_comb begin
    tag_busy_d    = tag_busy_q;
    reg_pending_d = reg_pending_q;
    reg_tag_d     = reg_tag_q;
    if (eu_hit) tag_busy_d[eu_tag_i] = 1'b0;
    if (accept) tag_busy_d[free_tag] = 1'b1;
    for (int r = 0; r < NumRegs; r++) begin
      if (eu_hit && reg_tag_q[r] == eu_tag_i) reg_pending_d[r] = 1'b0;
    end
    // A new writer of the same register overrides a same-cycle completion.
    if (accept && dec_has_dst_i) begin
      reg_pending_d[dec_dst_reg_i] = 1'b1;
      reg_tag_d[dec_dst_reg_i]     = free_tag;
    end
  end

  always_comb begin
    op_ready = '1;
    op_tags  = '0;
    src      = '0;
    for (int k = 0; k < OperandsPerInst; k++) begin
      src = dec_operands_i[k*RegIdxWidth +: RegIdxWidth];
      if (dec_operands_required_i[k]) begin
        op_ready[k] = !reg_pending_q[src] || (eu_hit && eu_tag_i == reg_tag_q[src]);
        op_tags[k*TagWidth +: TagWidth] = reg_tag_q[src];
      end
    end
  end

  always_comb begin
    snoop_ready = out_ready_q;
    for (int k = 0; k < OperandsPerInst; k++) begin
      if (eu_hit && out_op_tags_q[k*TagWidth +: TagWidth] == eu_tag_i) snoop_ready[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_busy_q     <= '0;
      reg_pending_q  <= '0;
      reg_tag_q      <= '{default: '0};
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      out_dst_q      <= '0;
      out_required_q <= '0;
      out_operands_q <= '0;
      out_tag_q      <= '0;
      out_ready_q    <= '0;
      out_op_tags_q  <= '0;
    end else if (flush) begin
      tag_busy_q    <= '0;
      reg_pending_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      tag_busy_q    <= tag_busy_d;
      reg_pending_q <= reg_pending_d;
      reg_tag_q     <= reg_tag_d;
      if (accept) begin
        out_valid_q    <= 1'b1;
        out_payload_q  <= dec_payload_i;
        out_dst_q      <= dec_dst_reg_i;
        out_required_q <= dec_operands_required_i;
        out_operands_q <= dec_operands_i;
        out_tag_q      <= free_tag;
        out_ready_q    <= op_ready;
        out_op_tags_q  <= op_tags;
      end else if (out_valid_q) begin
        out_ready_q <= snoop_ready;
        if (wb_ready_i) out_valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid_o             = out_valid_q;
  assign wb_payload_o           = out_payload_q;
  assign wb_dst_reg_o           = out_dst_q;
  assign wb_operands_required_o = out_required_q;
  assign wb_operands_o          = out_operands_q;
  assign wb_tag_o               = out_tag_q;
  assign wb_operands_ready_o    = out_ready_q;
  assign wb_operand_tags_o      = out_op_tags_q;

`ifndef SYNTHESIS
  completion_of_busy_tag: assert property (@(posedge clk_i) disable iff (!rst_ni || flush)
    eu_valid_i |-> tag_busy_q[eu_tag_i]);
`endif

endmodule

// File: tb/tb_tag_scoreboard.sv
// Directed self-checking bench for tag_scoreboard (default 8 tags, 6-bit regs, 2 operands).
module tb_tag_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_ni;
`ifdef TAG_SCOREBOARD_FLUSH_EN
  logic        flush_i;
`endif
  logic        dec_valid_i;
  logic        sb_ready_o;
  logic [63:0] dec_payload_i;
  logic        dec_has_dst_i;
  logic [5:0]  dec_dst_reg_i;
  logic [1:0]  dec_operands_required_i;
  logic [11:0] dec_operands_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_payload_o;
  logic [5:0]  wb_dst_reg_o;
  logic [1:0]  wb_operands_required_o;
  logic [11:0] wb_operands_o;
  logic [2:0]  wb_tag_o;
  logic [1:0]  wb_operands_ready_o;
  logic [5:0]  wb_operand_tags_o;
  logic        eu_valid_i;
  logic [2:0]  eu_tag_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  tag_scoreboard dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef TAG_SCOREBOARD_FLUSH_EN
    .flush_i(flush_i),
`endif
    .dec_valid_i(dec_valid_i), .sb_ready_o(sb_ready_o), .dec_payload_i(dec_payload_i),
    .dec_has_dst_i(dec_has_dst_i), .dec_dst_reg_i(dec_dst_reg_i),
    .dec_operands_required_i(dec_operands_required_i), .dec_operands_i(dec_operands_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_payload_o(wb_payload_o),
    .wb_dst_reg_o(wb_dst_reg_o), .wb_operands_required_o(wb_operands_required_o),
    .wb_operands_o(wb_operands_o), .wb_tag_o(wb_tag_o),
    .wb_operands_ready_o(wb_operands_ready_o), .wb_operand_tags_o(wb_operand_tags_o),
    .eu_valid_i(eu_valid_i), .eu_tag_i(eu_tag_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid_i             = 1'b0;
    dec_payload_i           = '0;
    dec_has_dst_i           = 1'b0;
    dec_dst_reg_i           = '0;
    dec_operands_required_i = '0;
    dec_operands_i          = '0;
    wb_ready_i              = 1'b1;
    eu_valid_i              = 1'b0;
    eu_tag_i                = '0;
`ifdef TAG_SCOREBOARD_FLUSH_EN
    flush_i                 = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  task automatic set_inst(input logic has_dst, input logic [5:0] dst, input logic [1:0] req,
                          input logic [5:0] op0, input logic [5:0] op1);
    dec_valid_i             = 1'b1;
    dec_has_dst_i           = has_dst;
    dec_dst_reg_i           = dst;
    dec_operands_required_i = req;
    dec_operands_i          = {op1, op0};
  endtask

  task automatic test_reset();
    idle_inputs();
    dec_valid_i = 1'b1;
    rst_ni = 1'b0;
    step();
    step();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wb_valid_o); end
    checks++; if (wb_tag_o !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", wb_tag_o); end
    checks++; if (wb_payload_o !== 64'd0) begin errors++; $display("FAIL reset_payload: got %h expected 0", wb_payload_o); end
    checks++; if (wb_operands_ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", wb_operands_ready_o); end
    dec_valid_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    checks++; if (sb_ready_o !== 1'b1) begin errors++; $display("FAIL reset_sb_ready: got %b expected 1", sb_ready_o); end
  endtask

  task automatic test_basic();
    do_reset();
    set_inst(1'b1, 6'd3, 2'b11, 6'd1, 6'd2);
    dec_payload_i = 64'hDEAD_BEEF_0123_4567;
    step();
    idle_inputs();
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", wb_valid_o); end
    checks++; if (wb_tag_o !== 3'd0) begin errors++; $display("FAIL basic_tag: got %0d expected 0", wb_tag_o); end
    checks++; if (wb_operands_ready_o !== 2'b11) begin errors++; $display("FAIL basic_ready: got %b expected 11", wb_operands_ready_o); end
    checks++; if (wb_dst_reg_o !== 6'd3) begin errors++; $display("FAIL basic_dst: got %0d expected 3", wb_dst_reg_o); end
    checks++; if (wb_payload_o !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL basic_payload: got %h expected deadbeef01234567", wb_payload_o); end
    checks++; if (wb_operands_o !== {6'd2, 6'd1}) begin errors++; $display("FAIL basic_operands: got %h expected %h", wb_operands_o, {6'd2, 6'd1}); end
    step();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", wb_valid_o); end
  endtask

  task automatic test_stall_snoop();
    do_reset();
    set_inst(1'b1, 6'd5, 2'b00, 6'd0, 6'd0);
    step();
    set_inst(1'b0, 6'd0, 2'b01, 6'd5, 6'd0);
    step();
    idle_inputs();
    wb_ready_i = 1'b0;
    #1;
    checks++; if (wb_tag_o !== 3'd1) begin errors++; $display("FAIL stall_tag: got %0d expected 1", wb_tag_o); end
    checks++; if (wb_operands_ready_o !== 2'b10) begin errors++; $display("FAIL stall_ready: got %b expected 10", wb_operands_ready_o); end
    checks++; if (wb_operand_tags_o !== 6'd0) begin errors++; $display("FAIL stall_optags: got %h expected 0", wb_operand_tags_o); end
    checks++; if (sb_ready_o !== 1'b0) begin errors++; $display("FAIL stall_sb_ready: got %b expected 0", sb_ready_o); end
    step();
    checks++; if (wb_operands_ready_o !== 2'b10) begin errors++; $display("FAIL stall_hold: got %b expected 10", wb_operands_ready_o); end
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd0;
    step();
    eu_valid_i = 1'b0;
    checks++; if (wb_operands_ready_o !== 2'b11) begin errors++; $display("FAIL snoop_ready: got %b expected 11", wb_operands_ready_o); end
    checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 3'd1) begin errors++; $display("FAIL snoop_entry: got valid=%b tag=%0d expected valid=1 tag=1", wb_valid_o, wb_tag_o); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_inst(1'b0, 6'd0, 2'b00, 6'd0, 6'd0);
    step();
    step();
    set_inst(1'b1, 6'd5, 2'b00, 6'd0, 6'd0);
    step();
    set_inst(1'b0, 6'd0, 2'b01, 6'd5, 6'd0);
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd2;
    #1;
    checks++; if (sb_ready_o !== 1'b1) begin errors++; $display("FAIL bypass_sb_ready: got %b expected 1", sb_ready_o); end
    step();
    eu_valid_i = 1'b0;
    checks++; if (wb_tag_o !== 3'd3) begin errors++; $display("FAIL bypass_tag: got %0d expected 3", wb_tag_o); end
    checks++; if (wb_operands_ready_o !== 2'b11) begin errors++; $display("FAIL bypass_ready: got %b expected 11", wb_operands_ready_o); end
    checks++; if (wb_operand_tags_o !== 6'd2) begin errors++; $display("FAIL bypass_optags: got %h expected 02", wb_operand_tags_o); end
    set_inst(1'b0, 6'd0, 2'b11, 6'd5, 6'd5);
    step();
    idle_inputs();
    checks++; if (wb_tag_o !== 3'd2) begin errors++; $display("FAIL bypass_reuse_tag: got %0d expected 2", wb_tag_o); end
    checks++; if (wb_operands_ready_o !== 2'b11) begin errors++; $display("FAIL bypass_after_ready: got %b expected 11", wb_operands_ready_o); end
  endtask

  task automatic test_exhaustion();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_inst(1'b0, 6'd0, 2'b00, 6'd0, 6'd0);
      step();
      checks++; if (wb_tag_o !== 3'(i)) begin errors++; $display("FAIL exhaust_tag%0d: got %0d expected %0d", i, wb_tag_o, i); end
    end
    #1;
    checks++; if (sb_ready_o !== 1'b0) begin errors++; $display("FAIL exhaust_full: got %b expected 0", sb_ready_o); end
    step();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL exhaust_no_accept: got %b expected 0", wb_valid_o); end
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd3;
    #1;
    checks++; if (sb_ready_o !== 1'b0) begin errors++; $display("FAIL exhaust_same_cycle: got %b expected 0", sb_ready_o); end
    step();
    eu_valid_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL exhaust_still_empty: got %b expected 0", wb_valid_o); end
    checks++; if (sb_ready_o !== 1'b1) begin errors++; $display("FAIL exhaust_freed: got %b expected 1", sb_ready_o); end
    step();
    idle_inputs();
    checks++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 3'd3) begin errors++; $display("FAIL exhaust_reuse: got valid=%b tag=%0d expected valid=1 tag=3", wb_valid_o, wb_tag_o); end
  endtask

  task automatic test_waw();
    do_reset();
    set_inst(1'b1, 6'd5, 2'b00, 6'd0, 6'd0);
    step();
    step();
    checks++; if (wb_tag_o !== 3'd1) begin errors++; $display("FAIL waw_second_tag: got %0d expected 1", wb_tag_o); end
    idle_inputs();
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd0;
    step();
    eu_valid_i = 1'b0;
    set_inst(1'b0, 6'd0, 2'b01, 6'd5, 6'd0);
    step();
    idle_inputs();
    checks++; if (wb_tag_o !== 3'd0) begin errors++; $display("FAIL waw_reader_tag: got %0d expected 0", wb_tag_o); end
    checks++; if (wb_operands_ready_o !== 2'b10) begin errors++; $display("FAIL waw_ready: got %b expected 10", wb_operands_ready_o); end
    checks++; if (wb_operand_tags_o !== 6'd1) begin errors++; $display("FAIL waw_optags: got %h expected 01", wb_operand_tags_o); end
  endtask

`ifdef TAG_SCOREBOARD_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_inst(1'b1, 6'(10 + i), 2'b00, 6'd0, 6'd0);
      step();
    end
    idle_inputs();
    flush_i = 1'b1;
    #1;
    checks++; if (sb_ready_o !== 1'b0) begin errors++; $display("FAIL flush_sb_ready: got %b expected 0", sb_ready_o); end
    step();
    flush_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", wb_valid_o); end
    set_inst(1'b0, 6'd0, 2'b11, 6'd10, 6'd13);
    step();
    idle_inputs();
    checks++; if (wb_tag_o !== 3'd0) begin errors++; $display("FAIL flush_tag: got %0d expected 0", wb_tag_o); end
    checks++; if (wb_operands_ready_o !== 2'b11) begin errors++; $display("FAIL flush_ready: got %b expected 11", wb_operands_ready_o); end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_basic();
    test_stall_snoop();
    test_bypass();
    test_exhaustion();
    test_waw();
`ifdef TAG_SCOREBOARD_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
